// File: rtl/pool_cfg_master.sv
// AXI4-Lite write master that programs a pooling engine: soft reset, frame size,
// KERNEL_SIZE^2 kernel words, then enable, one write in flight at a time.
module pool_cfg_master #(
    parameter int ADDR_WIDTH   = 10,
    parameter int KERNEL_SIZE  = 3,
    parameter int RESP_TIMEOUT = 256
) (
    input  logic                                   axi_clk,
    input  logic                                   axi_reset_n,
    input  logic                                   start,
    input  logic [15:0]                            cfg_width,
    input  logic [15:0]                            cfg_height,
    input  logic [32*KERNEL_SIZE*KERNEL_SIZE-1:0]  cfg_kernel,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [31:0]                            m_axi_wdata,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready
);

    localparam int K2    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NWR   = K2 + 4;
    localparam int IDX_W = $clog2(NWR + 1);
    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RESP, FINISH, FAIL} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [15:0]            width_q, height_q;
    logic [32*K2-1:0]       kern_q;
    logic                   cfg_load;

    // Register map: 0 enable, 4 soft reset, 16 width, 20 height, 24.. kernel words.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i == 0)           return ADDR_WIDTH'(4);
        else if (i == 1)      return ADDR_WIDTH'(16);
        else if (i == 2)      return ADDR_WIDTH'(20);
        else if (i < 3 + K2)  return ADDR_WIDTH'(24 + 4 * (i - 3));
        else                  return '0;
    endfunction

    function automatic logic [31:0] data_of(input logic [IDX_W-1:0] idx,
                                            input logic [15:0]      w,
                                            input logic [15:0]      h,
                                            input logic [32*K2-1:0] kern);
        int i;
        i = int'(idx);
        if (i == 1)                 return {16'd0, w};
        else if (i == 2)            return {16'd0, h};
        else if (i >= 3 && i < 3 + K2) return kern[32*(i-3) +: 32];
        else                        return 32'd1;
    endfunction

    assign cfg_load = (state_q == IDLE) && start;
    assign idx_nxt  = idx_q + IDX_W'(1);

    always_ff @(posedge axi_clk) begin
        if (cfg_load) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            kern_q   <= cfg_kernel;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WRITE;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = addr_of('0);
                    wdata_d   = data_of('0, cfg_width, cfg_height, cfg_kernel);
                end
            end
            WRITE: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                // Both channels finished in an earlier cycle: wait for the response.
                if (!awvalid_q && !wvalid_q) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                    tmo_d    = '0;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        state_d = FAIL;
                        error_d = 1'b1;
                    end else if (int'(idx_q) == NWR - 1) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = WRITE;
                        idx_d     = idx_nxt;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = addr_of(idx_nxt);
                        wdata_d   = data_of(idx_nxt, width_q, height_q, kern_q);
                    end
                end else if (tmo_q == TMO_W'(RESP_TIMEOUT - 1)) begin
                    state_d  = FAIL;
                    error_d  = 1'b1;
                    bready_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            FAIL: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_pool_cfg_master.sv
// Bench for pool_cfg_master: behavioural AXI4-Lite slave with configurable stalls,
// write log compared against a register-sequence model built from the configuration.
module tb_pool_cfg_master;
    localparam int K2 = 9;

    logic              axi_clk, axi_reset_n, start;
    logic [15:0]       cfg_width, cfg_height;
    logic [32*K2-1:0]  cfg_kernel;
    logic              busy, done, error;
    logic [9:0]        m_axi_awaddr;
    logic              m_axi_awvalid, m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic              m_axi_wvalid, m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid, m_axi_bready;

    pool_cfg_master #(.ADDR_WIDTH(10), .KERNEL_SIZE(3), .RESP_TIMEOUT(256)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_kernel(cfg_kernel),
        .busy(busy), .done(done), .error(error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int n_checks = 0, n_pass = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    logic [31:0] kern [K2];

    // slave configuration and state
    int  aw_dly = 0, w_dly = 0, b_dly = 0, bad_idx = -1;
    bit  rand_dly = 0, no_b = 0;
    int  aw_wait, w_wait, b_wait, b_idx;
    bit  aw_got, w_got, b_pending, b_hs_pend, outstanding, prev_awv, prev_wv;
    logic [9:0]  got_addr, prev_addr;
    logic [31:0] got_data, prev_data;
    logic [9:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic [9:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    int aw_hs_n, w_hs_n, done_n, bready_n, proto_err, awvalid_n, wvalid_n;

    initial begin
        axi_clk = 0;
        forever #5 axi_clk = ~axi_clk;
    end

    initial forever begin
        @(posedge axi_clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // AXI4-Lite slave and protocol monitor, evaluated once per cycle on the falling edge
    initial forever begin
        @(negedge axi_clk);
        if (!axi_reset_n) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_wait = 0; aw_got = 0; w_got = 0;
            b_pending = 0; b_hs_pend = 0; outstanding = 0; prev_awv = 0; prev_wv = 0;
        end else begin
            if (done) begin done_n++; done_cyc = cyc; end
            if (m_axi_bready) bready_n++;
            if (m_axi_awvalid) awvalid_n++;
            if (m_axi_wvalid) wvalid_n++;
            if (prev_awv && (!m_axi_awvalid || m_axi_awaddr !== prev_addr)) proto_err++;
            if (prev_wv && (!m_axi_wvalid || m_axi_wdata !== prev_data)) proto_err++;
            if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) proto_err++;
            if (outstanding && m_axi_awvalid && !aw_got) proto_err++;
            if (b_hs_pend) begin m_axi_bvalid = 0; b_hs_pend = 0; end
            if (b_pending && !no_b) begin
                if (b_wait >= b_dly) begin
                    m_axi_bvalid = 1;
                    m_axi_bresp = (b_idx == bad_idx) ? 2'b10 : 2'b00;
                    b_pending = 0;
                end else b_wait++;
            end
            if (m_axi_bvalid && m_axi_bready) begin b_hs_pend = 1; outstanding = 0; end
            m_axi_awready = 0;
            if (m_axi_awvalid && !aw_got) begin
                if (aw_wait >= aw_dly) begin
                    m_axi_awready = 1; got_addr = m_axi_awaddr; aw_got = 1; aw_wait = 0; aw_hs_n++;
                end else aw_wait++;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid && !w_got) begin
                if (w_wait >= w_dly) begin
                    m_axi_wready = 1; got_data = m_axi_wdata; w_got = 1; w_wait = 0; w_hs_n++;
                end else w_wait++;
            end
            if (aw_got && w_got) begin
                log_addr.push_back(got_addr);
                log_data.push_back(got_data);
                aw_got = 0; w_got = 0; b_pending = 1; b_wait = 0; outstanding = 1;
                b_idx = log_addr.size() - 1;
                if (rand_dly) begin
                    aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
                end
            end
            prev_awv = m_axi_awvalid && !m_axi_awready; prev_addr = m_axi_awaddr;
            prev_wv = m_axi_wvalid && !m_axi_wready; prev_data = m_axi_wdata;
        end
    end

    // Reference sequence: soft reset, width, height, kernel words, enable.
    function automatic void build_exp(input logic [15:0] w, input logic [15:0] h);
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(10'd4);  exp_data.push_back(32'd1);
        exp_addr.push_back(10'd16); exp_data.push_back({16'd0, w});
        exp_addr.push_back(10'd20); exp_data.push_back({16'd0, h});
        for (int i = 0; i < K2; i++) begin
            exp_addr.push_back(10'(24 + 4 * i)); exp_data.push_back(kern[i]);
        end
        exp_addr.push_back(10'd0);  exp_data.push_back(32'd1);
    endfunction

    function automatic int log_diffs(input int upto);
        int d = 0;
        if (log_addr.size() != upto) d++;
        for (int i = 0; i < upto && i < log_addr.size(); i++)
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) d++;
        return d;
    endfunction

    task automatic set_slave(input int awd, input int wd, input int bd, input bit rnd, input int bad, input bit nob);
        aw_dly = awd; w_dly = wd; b_dly = bd; rand_dly = rnd; bad_idx = bad; no_b = nob;
    endtask

    task automatic clear_log();
        @(posedge axi_clk); #1;
        log_addr.delete(); log_data.delete();
        aw_hs_n = 0; w_hs_n = 0; done_n = 0; bready_n = 0; proto_err = 0; awvalid_n = 0; wvalid_n = 0;
    endtask

    task automatic rand_kern();
        for (int i = 0; i < K2; i++) kern[i] = $urandom;
    endtask

    task automatic start_seq(input logic [15:0] w, input logic [15:0] h);
        @(negedge axi_clk);
        cfg_width = w; cfg_height = h;
        for (int i = 0; i < K2; i++) cfg_kernel[32*i +: 32] = kern[i];
        start = 1; start_cyc = cyc;
        @(negedge axi_clk);
        start = 0;
    endtask

    task automatic wait_idle(output bit to);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(negedge axi_clk); n++; end
        to = (busy !== 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge axi_clk); axi_reset_n = 0;
        repeat (2) @(negedge axi_clk);
        axi_reset_n = 1;
    endtask

    task automatic test_reset();
        axi_reset_n = 0;
        repeat (3) @(negedge axi_clk);
        n_checks++; if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else n_pass++;
        n_checks++; if (m_axi_awaddr !== 10'd0) $display("FAIL reset_awaddr: got %0h want 0", m_axi_awaddr); else n_pass++;
        n_checks++; if (m_axi_wdata !== 32'd0) $display("FAIL reset_wdata: got %0h want 0", m_axi_wdata); else n_pass++;
        axi_reset_n = 1;
        repeat (3) @(negedge axi_clk);
        n_checks++; if ({busy, m_axi_awvalid} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {busy, m_axi_awvalid}); else n_pass++;
    endtask

    task automatic test_basic();
        bit to;
        set_slave(0, 0, 0, 0, -1, 0);
        for (int i = 0; i < K2; i++) kern[i] = (i == 4) ? 32'd1 : 32'd0;
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        n_checks++; if ({busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b1110)
            $display("FAIL basic_first_cycle: got %b want 1110", {busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else n_pass++;
        n_checks++; if (m_axi_awaddr !== 10'd4 || m_axi_wdata !== 32'd1)
            $display("FAIL basic_first_beat: got %0d/%0d want 4/1", m_axi_awaddr, m_axi_wdata); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL basic_timeout: got busy stuck want idle"); else n_pass++;
        n_checks++; if (log_diffs(exp_addr.size()) != 0)
            $display("FAIL basic_writes: got %0d writes want %0d, %0d differ", log_addr.size(), exp_addr.size(), log_diffs(exp_addr.size())); else n_pass++;
        n_checks++; if (done_n != 1) $display("FAIL basic_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (done_cyc - start_cyc != 40) $display("FAIL basic_latency: got %0d want 40", done_cyc - start_cyc); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else n_pass++;
        n_checks++; if (proto_err != 0) $display("FAIL basic_protocol: got %0d violations want 0", proto_err); else n_pass++;
    endtask

    task automatic test_wready_early();
        bit to;
        set_slave(3, 0, 0, 0, -1, 0);
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        wait_idle(to);
        n_checks++; if (to) $display("FAIL wearly_timeout: got busy stuck want idle"); else n_pass++;
        n_checks++; if (log_diffs(exp_addr.size()) != 0)
            $display("FAIL wearly_writes: got %0d writes want %0d", log_addr.size(), exp_addr.size()); else n_pass++;
        n_checks++; if (aw_hs_n != 13 || w_hs_n != 13)
            $display("FAIL wearly_beats: got aw %0d w %0d want 13 13", aw_hs_n, w_hs_n); else n_pass++;
        n_checks++; if (wvalid_n != 13) $display("FAIL wearly_wvalid_cycles: got %0d want 13", wvalid_n); else n_pass++;
        n_checks++; if (awvalid_n != 52) $display("FAIL wearly_awvalid_cycles: got %0d want 52", awvalid_n); else n_pass++;
        n_checks++; if (proto_err != 0) $display("FAIL wearly_protocol: got %0d want 0", proto_err); else n_pass++;
        n_checks++; if (done_n != 1 || done_cyc - start_cyc != 79)
            $display("FAIL wearly_done: got %0d pulses at %0d want 1 at 79", done_n, done_cyc - start_cyc); else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        logic [15:0] w, h;
        for (int it = 0; it < 3; it++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1, -1, 0);
            rand_kern();
            w = 16'($urandom); h = 16'($urandom);
            clear_log(); build_exp(w, h);
            start_seq(w, h);
            wait_idle(to);
            n_checks++; if (to) $display("FAIL rand%0d_timeout: got busy stuck want idle", it); else n_pass++;
            n_checks++; if (log_diffs(exp_addr.size()) != 0)
                $display("FAIL rand%0d_writes: got %0d writes want %0d", it, log_addr.size(), exp_addr.size()); else n_pass++;
            n_checks++; if (done_n != 1 || error !== 1'b0)
                $display("FAIL rand%0d_status: got done %0d error %b want 1 0", it, done_n, error); else n_pass++;
            n_checks++; if (proto_err != 0) $display("FAIL rand%0d_protocol: got %0d want 0", it, proto_err); else n_pass++;
        end
    endtask

    task automatic test_cfg_change();
        bit to;
        set_slave(0, 0, 0, 0, -1, 0);
        rand_kern();
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        cfg_width = 16'd16; cfg_height = 16'($urandom);
        for (int i = 0; i < K2; i++) cfg_kernel[32*i +: 32] = $urandom;
        repeat (5) @(negedge axi_clk);
        start = 1;
        @(negedge axi_clk);
        start = 0;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL cfgchg_timeout: got busy stuck want idle"); else n_pass++;
        n_checks++; if (log_data.size() < 2 || log_data[1] !== 32'd8)
            $display("FAIL cfgchg_width: got %0d want 8", (log_data.size() < 2) ? 0 : log_data[1]); else n_pass++;
        n_checks++; if (log_diffs(exp_addr.size()) != 0)
            $display("FAIL cfgchg_writes: got %0d writes want %0d", log_addr.size(), exp_addr.size()); else n_pass++;
        n_checks++; if (done_n != 1) $display("FAIL cfgchg_done: got %0d want 1", done_n); else n_pass++;
    endtask

    task automatic test_bad_resp();
        bit to;
        set_slave(0, 0, 0, 0, 2, 0);
        rand_kern();
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        wait_idle(to);
        repeat (5) @(negedge axi_clk);
        n_checks++; if (to) $display("FAIL badresp_timeout: got busy stuck want idle"); else n_pass++;
        n_checks++; if (log_diffs(3) != 0) $display("FAIL badresp_writes: got %0d writes want 3", log_addr.size()); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL badresp_error: got %b want 1", error); else n_pass++;
        n_checks++; if (done_n != 0) $display("FAIL badresp_done: got %0d want 0", done_n); else n_pass++;
        set_slave(0, 0, 0, 0, -1, 0);
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        n_checks++; if (error !== 1'b0) $display("FAIL badresp_error_clear: got %b want 0", error); else n_pass++;
        wait_idle(to);
        n_checks++; if (log_diffs(exp_addr.size()) != 0)
            $display("FAIL badresp_retry_writes: got %0d writes want %0d", log_addr.size(), exp_addr.size()); else n_pass++;
        n_checks++; if (done_n != 1 || error !== 1'b0)
            $display("FAIL badresp_retry_status: got done %0d error %b want 1 0", done_n, error); else n_pass++;
    endtask

    task automatic test_timeout();
        bit to;
        reset_dut();
        set_slave(0, 0, 0, 0, -1, 1);
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        wait_idle(to);
        repeat (10) @(negedge axi_clk);
        n_checks++; if (to) $display("FAIL tmo_stuck: got busy stuck want idle"); else n_pass++;
        n_checks++; if (error !== 1'b1 || busy !== 1'b0)
            $display("FAIL tmo_status: got error %b busy %b want 1 0", error, busy); else n_pass++;
        n_checks++; if (bready_n != 256) $display("FAIL tmo_resp_cycles: got %0d want 256", bready_n); else n_pass++;
        n_checks++; if (awvalid_n != 1 || log_addr.size() != 1)
            $display("FAIL tmo_bus_quiet: got awvalid cycles %0d writes %0d want 1 1", awvalid_n, log_addr.size()); else n_pass++;
        n_checks++; if (done_n != 0) $display("FAIL tmo_done: got %0d want 0", done_n); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0, snap;
        reset_dut();
        set_slave(0, 0, 0, 0, -1, 0);
        rand_kern();
        clear_log(); build_exp(16'd8, 16'd8);
        start_seq(16'd8, 16'd8);
        while (!(m_axi_awvalid === 1'b1 && m_axi_awaddr === 10'd44) && n < 500) begin @(negedge axi_clk); n++; end
        n_checks++; if (n >= 500) $display("FAIL rstmid_reach_kernel5: got no write to 44 want one"); else n_pass++;
        @(posedge axi_clk); #2;
        axi_reset_n = 0;
        #1;
        n_checks++; if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 6'b0 || m_axi_awaddr !== 10'd0 || m_axi_wdata !== 32'd0)
            $display("FAIL rstmid_outputs: got ctrl %b addr %0h data %0h want 0", {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_awaddr, m_axi_wdata); else n_pass++;
        n_checks++; if (log_diffs(9) != 0) $display("FAIL rstmid_partial: got %0d writes want 9", log_addr.size()); else n_pass++;
        repeat (3) @(negedge axi_clk);
        axi_reset_n = 1;
        @(posedge axi_clk); #1;
        awvalid_n = 0; snap = log_addr.size();
        repeat (20) @(negedge axi_clk);
        n_checks++; if (awvalid_n != 0 || log_addr.size() != snap || busy !== 1'b0)
            $display("FAIL rstmid_quiet: got awvalid cycles %0d new writes %0d busy %b want 0 0 0", awvalid_n, log_addr.size() - snap, busy); else n_pass++;
        rand_kern();
        clear_log(); build_exp(16'd33, 16'd21);
        start_seq(16'd33, 16'd21);
        wait_idle(to);
        n_checks++; if (log_diffs(exp_addr.size()) != 0)
            $display("FAIL rstmid_restart_writes: got %0d writes want %0d", log_addr.size(), exp_addr.size()); else n_pass++;
        n_checks++; if (done_n != 1 || error !== 1'b0)
            $display("FAIL rstmid_restart_status: got done %0d error %b want 1 0", done_n, error); else n_pass++;
    endtask

    initial begin
        axi_reset_n = 0; start = 0; cfg_width = '0; cfg_height = '0; cfg_kernel = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        test_reset();
        test_basic();
        test_wready_early();
        test_random();
        test_cfg_change();
        test_bad_resp();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_cfg_master.md
POOL_CFG_MASTER -- requirements
Module: pool_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning AXI4-Lite address width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, meaning pooling window side; K2 = KERNEL_SIZE*KERNEL_SIZE kernel words.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 256, meaning max cycles waiting for bvalid.
REQ-004 SHALL have ports:
  axi_clk  in  1  sole clock, rising edge
  axi_reset_n  in  1  asynchronous, active-low reset
  start  in  1  one-cycle request to run configuration sequence
  cfg_width  in  16  frame width in pixels
  cfg_height  in  16  frame height in lines
  cfg_kernel  in  32*K2  kernel words, word i at bits [32i+31:32i]
  busy  out  1  sequence in progress
  done  out  1  one-cycle pulse, sequence completed OK
  error  out  1  sticky, bad response or timeout
  m_axi_awaddr  out  ADDR_WIDTH  write address
  m_axi_awvalid  out  1  address valid
  m_axi_awready  in  1  address accepted
  m_axi_wdata  out  32  write data
  m_axi_wvalid  out  1  data valid
  m_axi_wready  in  1  data accepted
  m_axi_bresp  in  2  write response, 2'b00 = OKAY
  m_axi_bvalid  in  1  response valid
  m_axi_bready  out  1  response accept

Function
REQ-005 SHALL issue, per start, exactly 3+K2+1 single-beat writes in order: addr 4 data 1 (soft reset); addr 16 cfg_width zero-extended; addr 20 cfg_height zero-extended; addr 24+4i cfg_kernel word i, i=0..K2-1; addr 0 data 1 (enable) last.
REQ-006 SHALL sample cfg_width, cfg_height, cfg_kernel into internal registers on the accepted start cycle; later input changes SHALL not affect the running sequence.
REQ-007 SHALL implement states IDLE, WRITE, RESP, FINISH, FAIL.
REQ-008 IDLE: start=1 -> WRITE with write index 0, error cleared; start ignored in all other states.
REQ-009 WRITE: awvalid and wvalid asserted in the same first cycle; each SHALL stay high until its own handshake (valid&ready) completes; handshakes MAY complete in the same or different cycles, in either order.
REQ-010 awaddr/wdata SHALL remain stable while corresponding valid is high.
REQ-011 WRITE -> RESP on the cycle after both handshakes have completed; bready SHALL be 1 only in RESP.
REQ-012 RESP: bvalid=1 and bresp=00 -> index+1, return to WRITE, or FINISH if last write; bvalid=1 and bresp!=00 -> FAIL.
REQ-013 RESP timeout counter SHALL clear on entry; reaching RESP_TIMEOUT cycles without bvalid -> FAIL.
REQ-014 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-015 FAIL: error set (sticky), no further writes, next cycle IDLE; error cleared only by a new start or reset.
REQ-016 busy SHALL be 1 in WRITE, RESP, FINISH, FAIL; 0 in IDLE.
REQ-017 Minimum time per write with zero-wait slave SHALL be 3 cycles (WRITE handshake, RESP entry, bvalid accepted); minimum start-to-done 3*(3+K2+1)+1 cycles.
REQ-018 No more than one write SHALL be outstanding at any time.

Reset
REQ-019 axi_reset_n=0 SHALL asynchronously force IDLE; awvalid, wvalid, bready, busy, done, error, awaddr, wdata all 0; index and timeout counter 0.
REQ-020 Reset asserted mid-sequence SHALL abandon the sequence; no write SHALL be issued after reset release until a new start.

Verification
REQ-021 Zero-wait slave, start with width 8, height 8, kernel word 4 = 1 others 0 -> 13 writes: (4,1),(16,8),(20,8),(24,0)..(40,1)..(56,0),(0,1); done pulses once at cycle 40; error 0.
REQ-022 Slave asserts wready 3 cycles before awready on every write -> wvalid drops after its handshake, awvalid holds, same 13 writes, no duplicated beats.
REQ-023 Slave returns bresp=2'b10 on the height write -> FAIL, error=1, no kernel or enable writes, done never pulses; following start clears error and completes.
REQ-024 Slave never asserts bvalid on first write -> error=1 after 256 RESP cycles, busy falls, awvalid stays 0.
REQ-025 Reset pulsed during kernel write 5 -> all outputs 0 immediately, no further bus activity; later start runs full 13-write sequence from index 0.
REQ-026 cfg_width changed to 16 one cycle after start -> width write still carries 8.
